i2c_cmd_sequencer: RTL and testbench

Command front end for the I2C controller: accepts I2C transaction descriptors over a valid/ready handshake, buffers them in a small FIFO and issues them one at a time to the controller. It drives the controller's `init_transaction`, `rw`, `address`, `data` and `bytesend` inputs, holding them stable for the whole transaction. It tracks completion through the controller's `ctrl_busy` status, then enforces an inter-transaction gap before issuing the next command.

---
 rtl/i2c_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues I2C transaction descriptors in a small FIFO and
// issues them one at a time to the I2C controller. It waits for the
// controller to go busy and then idle again, and enforces an idle gap
// between transactions.
// Optional feature macro: I2C_SEQ_TIMEOUT_EN adds a per-transaction watchdog
// that aborts a stuck wait with a timeout_err pulse.
module i2c_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_rw,
    input  logic [6:0]                   cmd_address,
    input  logic [31:0]                  cmd_data,
    input  logic [3:0]                   cmd_bytesend,
    input  logic                         ctrl_busy,
    output logic                         init_transaction,
    output logic                         rw,
    output logic [6:0]                   address,
    output logic [31:0]                  data,
    output logic [3:0]                   bytesend,
    output logic                         done,
    output logic                         timeout_err,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         seq_busy
);

    localparam int DW = 44;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [GW-1:0]   gap_cnt;
    logic            push;
    logic            pop;

    // Unsupported parameter values (non power-of-two depth, zero gap or
    // zero watchdog limit) are flagged by this block existing in the
    // elaborated hierarchy; it holds no logic.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
    end

    assign cmd_ready  = (count != FULL_COUNT);
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == LOAD);
    assign fifo_count = count;
    assign seq_busy   = (state != IDLE);

    // Descriptor storage: plain array, read only through the LOAD capture.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_rw, cmd_address, cmd_data, cmd_bytesend};
        end
    end

    // FIFO pointers and occupancy; a push and a pop together leave count unchanged.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Issue state machine with registered strobes and descriptor outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            init_transaction <= 1'b0;
            done             <= 1'b0;
            rw               <= 1'b0;
            address          <= '0;
            data             <= '0;
            bytesend         <= '0;
            gap_cnt          <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            timeout_err      <= 1'b0;
            wd_cnt           <= '0;
`endif
        end else begin
            init_transaction <= 1'b0;
            done             <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            timeout_err      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    {rw, address, data, bytesend} <= mem[rd_ptr];
                    init_transaction <= 1'b1;
                    state            <= START;
                end
                START: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    wd_cnt <= wd_cnt + TW'(1);
                    if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else if (ctrl_busy) begin
                        state <= WAIT_DONE;
                    end
`else
                    if (ctrl_busy) begin
                        state <= WAIT_DONE;
                    end
`endif
                end
                WAIT_DONE: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    wd_cnt <= wd_cnt + TW'(1);
`endif
                    // Normal completion wins over a watchdog expiring in the same cycle.
                    if (!ctrl_busy) begin
                        done    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Testbench for i2c_cmd_sequencer: a transaction-level reference model
// (queue of accepted commands plus issue/completion timing rules) checks
// every cycle; a table of single-command vectors and a few directed
// sequences cover fill, simultaneous push/pop, reset and timeout; a
// randomized phase follows. Honours I2C_SEQ_TIMEOUT_EN if defined.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;
    localparam int TO    = 100;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                        clock = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        cmd_valid = 1'b0;
    logic                        cmd_ready;
    logic                        cmd_rw = 1'b0;
    logic [6:0]                  cmd_address = '0;
    logic [31:0]                 cmd_data = '0;
    logic [3:0]                  cmd_bytesend = '0;
    logic                        ctrl_busy = 1'b0;
    logic                        init_transaction;
    logic                        rw;
    logic [6:0]                  address;
    logic [31:0]                 data;
    logic [3:0]                  bytesend;
    logic                        done;
    logic                        timeout_err;
    logic [$clog2(DEPTH+1)-1:0]  fifo_count;
    logic                        seq_busy;

    i2c_cmd_sequencer #(
        .DEPTH          (DEPTH),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rw           (cmd_rw),
        .cmd_address      (cmd_address),
        .cmd_data         (cmd_data),
        .cmd_bytesend     (cmd_bytesend),
        .ctrl_busy        (ctrl_busy),
        .init_transaction (init_transaction),
        .rw               (rw),
        .address          (address),
        .data             (data),
        .bytesend         (bytesend),
        .done             (done),
        .timeout_err      (timeout_err),
        .fifo_count       (fifo_count),
        .seq_busy         (seq_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [43:0] desc;
        int          acc;
    } qent_t;

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  nbytes;
        int          dly;
        int          len;
        int          init_lat;
        int          done_lat;
        int          idle_lat;
    } vec_t;

    qent_t       q[$];
    logic [6:0]  issued[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          active = 1'b0;
    bit          txn_stuck = 1'b0;
    bit          stuck_mode = 1'b0;
    bit          rand_mode = 1'b0;
    int          s_cyc = 0;
    int          done_at = 0;
    int          last_done = -1000;
    int          last_init = -1000;
    int          last_fall = -1000;
    int          last_push = -1000;
    int          init_cnt = 0;
    int          done_cnt = 0;
    int          to_seen = 0;
    int          bus_dly = 2;
    int          bus_len = 5;
    int          cur_dly = 2;
    int          cur_len = 5;
    logic [43:0] cur_desc = '0;
    bit          prev_seq_busy = 1'b0;
    bit          saw_full = 1'b0;
    bit          want_valid = 1'b0;
    bit          want_rst = 1'b0;
    bit          pushed_now = 1'b0;
    logic [43:0] want_desc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of the reference model: sample DUT, compare, then drive inputs.
    task automatic cycle();
        bit exp_init;
        bit exp_load;
        bit exp_done;
        bit exp_to;
        bit sb_exp;
        int t_init;
        @(posedge clock);
        #1;
        cyc++;
        if (!reset_n) begin
            q.delete();
            active    = 1'b0;
            last_done = -1000;
            cur_desc  = '0;
        end
        exp_init = 1'b0;
        exp_load = 1'b0;
        if (!active && q.size() > 0) begin
            // Next strobe: after the previous gap ends, and never sooner than 3 clocks after acceptance.
            t_init = (last_done + GAP + 2 > q[0].acc + 3) ? last_done + GAP + 2 : q[0].acc + 3;
            exp_init = (cyc == t_init);
            exp_load = (cyc == t_init - 1);
        end
        check("init_transaction", init_transaction, exp_init);
        if (exp_init) begin
            cur_desc = q[0].desc;
            q.delete(0);
            issued.push_back(cur_desc[42:36]);
            active    = 1'b1;
            s_cyc     = cyc;
            last_init = cyc;
            init_cnt++;
            txn_stuck = stuck_mode;
            if (rand_mode) begin
                cur_dly = $urandom_range(1, 4);
                cur_len = $urandom_range(1, 30);
            end else begin
                cur_dly = bus_dly;
                cur_len = bus_len;
            end
            if (txn_stuck) done_at = TO_EN ? cyc + 1 + TO : 32'h4000_0000;
            else           done_at = cyc + cur_dly + cur_len + 1;
            $display("txn %0d: cycle=%0d rw=%0d addr=%0h data=%0h bytes=%0d busy_dly=%0d busy_len=%0d",
                     init_cnt, cyc, cur_desc[43], cur_desc[42:36], cur_desc[35:4], cur_desc[3:0],
                     cur_dly, txn_stuck ? -1 : cur_len);
        end
        check("descriptor_out", {rw, address, data, bytesend}, cur_desc);
        exp_done = active && (cyc == done_at) && !txn_stuck;
        exp_to   = active && (cyc == done_at) && txn_stuck;
        check("done", done, exp_done);
        check("timeout_err", timeout_err, exp_to);
        if (timeout_err) to_seen++;
        if (exp_done) done_cnt++;
        if (exp_done || exp_to) begin
            active    = 1'b0;
            last_done = cyc;
        end
        check("fifo_count", fifo_count, q.size());
        check("cmd_ready", cmd_ready, q.size() < DEPTH);
        if (!cmd_ready) saw_full = 1'b1;
        sb_exp = active || (cyc <= last_done + GAP - 1) || exp_load;
        check("seq_busy", seq_busy, sb_exp);
        if (prev_seq_busy && !seq_busy) last_fall = cyc;
        prev_seq_busy = seq_busy;

        // Controller model: busy for cur_len clocks starting cur_dly after the strobe.
        ctrl_busy = active && !txn_stuck && (cyc >= s_cyc + cur_dly) && (cyc < s_cyc + cur_dly + cur_len);
        reset_n   = !want_rst;
        cmd_valid = want_valid;
        {cmd_rw, cmd_address, cmd_data, cmd_bytesend} = want_desc;
        pushed_now = want_valid && cmd_ready && !want_rst;
        if (pushed_now) begin
            q.push_back('{want_desc, cyc});
            last_push = cyc;
        end
    endtask

    task automatic push_cmd(input logic [43:0] d);
        int n;
        n = 0;
        want_valid = 1'b1;
        want_desc  = d;
        do begin
            cycle();
            n++;
        end while (!pushed_now && n < 300);
        want_valid = 1'b0;
        check("push_accepted", pushed_now, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((active || q.size() > 0 || seq_busy) && n < bound) begin
            cycle();
            n++;
        end
        check("idle_reached", !(active || q.size() > 0 || seq_busy), 1'b1);
    endtask

    task automatic apply_reset();
        want_rst = 1'b1;
        cycle();
        want_rst = 1'b0;
        cycle();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit cycle=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs[4];
        int   n;
        int   i0;
        int   d0;
        logic [43:0] rd;

        // Single commands into an idle, empty sequencer; latencies relative to push / strobe.
        vecs[0] = '{1'b1, 7'h3C, 32'hA5A5_0001, 4'd4, 2, 50, 3, 53, 69};
        vecs[1] = '{1'b0, 7'h7F, 32'hFFFF_FFFF, 4'd15, 1, 1, 3, 3, 19};
        vecs[2] = '{1'b1, 7'h00, 32'h0000_0000, 4'd0, 3, 10, 3, 14, 30};
        vecs[3] = '{1'b0, 7'h55, 32'h1234_5678, 4'd8, 4, 7, 3, 12, 28};

        want_rst = 1'b1;
        cycle();
        cycle();
        want_rst = 1'b0;
        cycle();
        check("reset_fifo_count", fifo_count, 0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_seq_busy", seq_busy, 1'b0);

        // Table-driven single transactions.
        foreach (vecs[i]) begin
            bus_dly = vecs[i].dly;
            bus_len = vecs[i].len;
            push_cmd({vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].nbytes});
            n = last_push;
            wait_idle(400);
            check("tbl_init_latency", last_init - n, vecs[i].init_lat);
            check("tbl_done_latency", last_done - last_init, vecs[i].done_lat);
            check("tbl_idle_latency", last_fall - last_init, vecs[i].idle_lat);
            check("tbl_fifo_empty", fifo_count, 0);
        end

        // Fill: six back-to-back pushes, the last one must wait for room.
        issued.delete();
        saw_full = 1'b0;
        bus_dly = 2;
        bus_len = 30;
        for (int a = 1; a <= 6; a++) begin
            push_cmd({1'b0, 7'(a), 32'(a * 3), 4'd1});
        end
        wait_idle(2000);
        check("fill_saw_full", saw_full, 1'b1);
        check("fill_issue_count", issued.size(), 6);
        for (int a = 0; a < 6; a++) begin
            rd = '0;
            if (a < issued.size()) rd[6:0] = issued[a];
            check("fill_order", rd[6:0], 7'(a + 1));
        end

        // Push landing in the LOAD cycle while two entries are queued.
        issued.delete();
        bus_dly = 2;
        bus_len = 20;
        d0 = done_cnt;
        push_cmd({1'b1, 7'h11, 32'h11, 4'd1});
        push_cmd({1'b1, 7'h12, 32'h12, 4'd2});
        push_cmd({1'b1, 7'h13, 32'h13, 4'd3});
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            cycle();
            n++;
        end
        check("simul_first_done", done_cnt > d0, 1'b1);
        while (cyc < last_done + GAP) cycle();
        want_valid = 1'b1;
        want_desc  = {1'b1, 7'h14, 32'h14, 4'd4};
        cycle();
        want_valid = 1'b0;
        check("simul_push_accepted", pushed_now, 1'b1);
        check("simul_count_at_load", fifo_count, 2);
        cycle();
        check("simul_count_after", fifo_count, 2);
        check("simul_strobe_after_load", init_transaction, 1'b1);
        wait_idle(2000);
        check("simul_issue_count", issued.size(), 4);
        for (int a = 0; a < 4; a++) begin
            rd = '0;
            if (a < issued.size()) rd[6:0] = issued[a];
            check("simul_order", rd[6:0], 7'h11 + 7'(a));
        end

        // Reset while waiting for the controller to finish, with 3 queued.
        issued.delete();
        bus_dly = 2;
        bus_len = 50;
        i0 = init_cnt;
        for (int a = 0; a < 4; a++) begin
            push_cmd({1'b0, 7'h21 + 7'(a), 32'hC0DE_0000 + 32'(a), 4'd2});
        end
        n = 0;
        while (init_cnt == i0 && n < 100) begin
            cycle();
            n++;
        end
        while (cyc < last_init + 10) cycle();
        check("rst_pre_count", fifo_count, 3);
        apply_reset();
        check("rst_fifo_count", fifo_count, 0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_seq_busy", seq_busy, 1'b0);
        check("rst_outputs", {init_transaction, done, timeout_err, rw, address, data, bytesend}, 0);
        repeat (40) cycle();
        check("rst_no_reissue", issued.size(), 1);
        push_cmd({1'b1, 7'h25, 32'hBEEF_0025, 4'd3});
        wait_idle(400);
        check("rst_new_issue_count", issued.size(), 2);
        rd = '0;
        if (issued.size() > 1) rd[6:0] = issued[1];
        check("rst_new_issue_addr", rd[6:0], 7'h25);

        // Controller never goes busy.
        issued.delete();
        d0 = to_seen;
        i0 = init_cnt;
        stuck_mode = 1'b1;
        push_cmd({1'b0, 7'h31, 32'h31, 4'd1});
        n = 0;
        while (init_cnt == i0 && n < 100) begin
            cycle();
            n++;
        end
        stuck_mode = 1'b0;
        bus_dly = 2;
        bus_len = 5;
        push_cmd({1'b0, 7'h32, 32'h32, 4'd1});
        if (TO_EN) begin
            wait_idle(600);
            check("to_pulse_count", to_seen - d0, 1);
            check("to_next_issued", issued.size(), 2);
        end else begin
            repeat (300) cycle();
            check("stuck_still_busy", seq_busy, 1'b1);
            check("stuck_no_timeout", to_seen - d0, 0);
            check("stuck_queue_held", fifo_count, 1);
            apply_reset();
            check("stuck_reset_idle", seq_busy, 1'b0);
        end

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        want_valid = 1'b0;
        for (int t = 0; t < 2500; t++) begin
            if (!want_valid || pushed_now) begin
                want_valid = ($urandom_range(0, 99) < 8);
                want_desc  = {1'($urandom_range(0, 1)), 7'($urandom), 32'($urandom), 4'($urandom)};
            end
            cycle();
        end
        want_valid = 1'b0;
        rand_mode = 1'b0;
        wait_idle(3000);
        check("final_fifo_empty", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
